// File: rtl/uart_ctrl_pkg.sv
//----------------------------------------------------------------------------
// uart_ctrl_pkg : shared constants and state encoding for uart_cmd_ctrl
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

package uart_ctrl_pkg;

  localparam logic [7:0] HDR_REQ  = 8'hA5;
  localparam logic [7:0] ST_OK    = 8'h5A;
  localparam logic [7:0] ST_ERR   = 8'hEE;
  localparam logic [7:0] CMD_WR   = 8'h01;
  localparam logic [7:0] CMD_RD   = 8'h02;
  localparam int         NUM_REGS = 4;
  localparam int         ADDR_W   = $clog2(NUM_REGS);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    ADDR = 3'd2,
    DATA = 3'd3,
    EXEC = 3'd4,
    TX0  = 3'd5,
    TX1  = 3'd6
  } state_e;

  function automatic logic cmd_known(input logic [7:0] c);
    return (c == CMD_WR) || (c == CMD_RD);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_ctrl_timeout.sv
//----------------------------------------------------------------------------
// uart_ctrl_timeout : saturating inter-byte gap counter with expire pulse
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module uart_ctrl_timeout #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int            CW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (!en || clr) begin
      cnt_q <= '0;
    end else if (cnt_q != LIMIT) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // A byte arriving on the limit cycle wins over the timeout
  assign expire = en && !clr && (cnt_q == LIMIT);

endmodule

`default_nettype wire

// File: rtl/uart_cmd_ctrl.sv
//----------------------------------------------------------------------------
// uart_cmd_ctrl : request-frame parser, 4x8 register file, 2-byte responder
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module uart_cmd_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_data_vld,
  output logic [7:0] tx_data,
  output logic       tx_data_vld,
  input  logic       tx_ready,
  output logic [7:0] led,
  output logic       busy,
  output logic       frame_err
);

  state_e     state_q;
  logic [7:0] cmd_q;
  logic [7:0] addr_q;
  logic [7:0] wdata_q;
  logic       bad_cmd_q;
  logic [7:0] val_q;
  logic [7:0] tx_data_q;
  logic       tx_vld_q;
  logic       ferr_q;
  logic [7:0] regs_q [NUM_REGS];
  logic       w_expire;
  logic       w_in_frame;

  assign w_in_frame = (state_q == CMD) || (state_q == ADDR) || (state_q == DATA);

  uart_ctrl_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .en     (w_in_frame),
    .clr    (rx_data_vld),
    .expire (w_expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cmd_q     <= 8'h00;
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
      bad_cmd_q <= 1'b0;
      val_q     <= 8'h00;
      tx_data_q <= 8'h00;
      tx_vld_q  <= 1'b0;
      ferr_q    <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == 0) ? 8'hFF : 8'h00;
      end
    end else begin
      ferr_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (rx_data_vld && (rx_data == HDR_REQ)) begin
            bad_cmd_q <= 1'b0;
            state_q   <= CMD;
          end
        end
        CMD: begin
          if (rx_data_vld) begin
            cmd_q <= rx_data;
            if (cmd_known(rx_data)) begin
              state_q <= ADDR;
            end else begin
              bad_cmd_q <= 1'b1;
              state_q   <= EXEC;
            end
          end else if (w_expire) begin
            ferr_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        ADDR: begin
          if (rx_data_vld) begin
            addr_q  <= rx_data;
            state_q <= (cmd_q == CMD_WR) ? DATA : EXEC;
          end else if (w_expire) begin
            ferr_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        DATA: begin
          if (rx_data_vld) begin
            wdata_q <= rx_data;
            state_q <= EXEC;
          end else if (w_expire) begin
            ferr_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        EXEC: begin
          // Address range is judged here so a bad-address write still consumes DATA
          tx_vld_q <= 1'b1;
          state_q  <= TX0;
          if (bad_cmd_q) begin
            tx_data_q <= ST_ERR;
            val_q     <= cmd_q;
          end else if (addr_q >= 8'(NUM_REGS)) begin
            tx_data_q <= ST_ERR;
            val_q     <= addr_q;
          end else if (cmd_q == CMD_WR) begin
            tx_data_q                   <= ST_OK;
            val_q                       <= wdata_q;
            regs_q[addr_q[ADDR_W-1:0]]  <= wdata_q;
          end else begin
            tx_data_q <= ST_OK;
            val_q     <= regs_q[addr_q[ADDR_W-1:0]];
          end
        end
        TX0: begin
          if (tx_ready) begin
            tx_data_q <= val_q;
            state_q   <= TX1;
          end
        end
        TX1: begin
          if (tx_ready) begin
            tx_vld_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_data_vld = tx_vld_q;
  assign led         = regs_q[0];
  assign busy        = (state_q != IDLE);
  assign frame_err   = ferr_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
//----------------------------------------------------------------------------
// tb_uart_cmd_ctrl : directed self-checking bench with frame-level model
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_uart_cmd_ctrl;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_data_vld = 1'b0;
  logic       tx_ready = 1'b1;
  logic [7:0] tx_data;
  logic       tx_data_vld;
  logic [7:0] led;
  logic       busy;
  logic       frame_err;

  int checks = 0;
  int errors = 0;
  int ferr_seen = 0;
  int f0;

  logic [7:0] mreg [4];
  logic [7:0] exp_q [$];
  logic       prev_vld = 1'b0;
  logic       prev_acc = 1'b0;
  logic [7:0] prev_data = 8'h00;

  uart_cmd_ctrl #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_data_vld (rx_data_vld),
    .tx_data     (tx_data),
    .tx_data_vld (tx_data_vld),
    .tx_ready    (tx_ready),
    .led         (led),
    .busy        (busy),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Frame-level model: response and register effect from the protocol rules
  task automatic model_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d);
    if (c != 8'h01 && c != 8'h02) begin
      exp_q.push_back(8'hEE); exp_q.push_back(c);
    end else if (a > 8'd3) begin
      exp_q.push_back(8'hEE); exp_q.push_back(a);
    end else if (c == 8'h01) begin
      mreg[a[1:0]] = d;
      exp_q.push_back(8'h5A); exp_q.push_back(d);
    end else begin
      exp_q.push_back(8'h5A); exp_q.push_back(mreg[a[1:0]]);
    end
  endtask

  task automatic model_reset();
    mreg[0] = 8'hFF; mreg[1] = 8'h00; mreg[2] = 8'h00; mreg[3] = 8'h00;
    exp_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data     = b;
    rx_data_vld = 1'b1;
    @(posedge clk); #1;
    rx_data_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input int n, input logic [7:0] c, input logic [7:0] a, input logic [7:0] d);
    send_byte(8'hA5);
    send_byte(c);
    if (n > 2) send_byte(a);
    if (n > 3) send_byte(d);
    model_frame(c, a, d);
  endtask

  // Called in cycle k+1 after the final byte; inspects cycle k+2
  task automatic check_first(input logic [7:0] status, input logic [7:0] led_exp);
    @(posedge clk); #1;
    chk("status_vld_k2", tx_data_vld, 1);
    chk("status_byte_k2", tx_data, status);
    chk("led_k2", led, led_exp);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("resp_done", {31'd0, (exp_q.size() == 0) && !busy}, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tx_data"}, tx_data, 8'h00);
    chk({tag, "_tx_vld"}, tx_data_vld, 0);
    chk({tag, "_led"}, led, 8'hFF);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
  endtask

  // Compare process: handshake bytes against the model, hold/stability, idle LED
  always @(negedge clk) begin
    if (!rst) begin
      prev_vld = 1'b0;
      prev_acc = 1'b0;
    end else begin
      if (prev_vld && !prev_acc) begin
        chk("tx_vld_hold", tx_data_vld, 1);
        chk("tx_data_stable", tx_data, prev_data);
      end
      if (tx_data_vld && tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected actual=%0h expected=none", tx_data);
        end else begin
          chk("tx_byte", tx_data, exp_q.pop_front());
        end
      end
      if (!busy) chk("led_idle", led, mreg[0]);
      if (frame_err) ferr_seen++;
      prev_vld  = tx_data_vld;
      prev_acc  = tx_data_vld && tx_ready;
      prev_data = tx_data;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;
    idle(2);

    // Reads after reset
    send_frame(3, 8'h02, 8'h00, 8'h00);
    check_first(8'h5A, 8'hFF);
    wait_done();
    send_frame(3, 8'h02, 8'h02, 8'h00);
    wait_done();

    // Writes and read-back
    send_frame(4, 8'h01, 8'h00, 8'h3C);
    check_first(8'h5A, 8'h3C);
    wait_done();
    send_frame(3, 8'h02, 8'h00, 8'h00);
    wait_done();
    send_frame(4, 8'h01, 8'h03, 8'h81);
    wait_done();
    send_frame(3, 8'h02, 8'h03, 8'h00);
    wait_done();

    // Unknown command answered right after the CMD byte
    send_frame(2, 8'h07, 8'h00, 8'h00);
    check_first(8'hEE, 8'h3C);
    wait_done();

    // Bad address: write consumes DATA but changes nothing; read errors too
    send_frame(4, 8'h01, 8'h05, 8'hAA);
    wait_done();
    send_frame(3, 8'h02, 8'h04, 8'h00);
    wait_done();
    for (int a = 0; a < 4; a++) begin
      send_frame(3, 8'h02, 8'(a), 8'h00);
      wait_done();
    end

    // Non-header bytes in IDLE are discarded
    send_byte(8'h11);
    send_byte(8'h02);
    send_byte(8'h00);
    idle(5);
    chk("idle_discard_busy", busy, 0);

    // Timeouts: no response, no write, one pulse each
    f0 = ferr_seen;
    send_byte(8'hA5);
    send_byte(8'h01);
    idle(20);
    chk("timeout1_pulses", ferr_seen - f0, 1);
    chk("timeout1_busy", busy, 0);
    f0 = ferr_seen;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h01);
    idle(20);
    chk("timeout2_pulses", ferr_seen - f0, 1);
    send_frame(3, 8'h02, 8'h00, 8'h00);
    wait_done();
    send_frame(3, 8'h02, 8'h01, 8'h00);
    wait_done();

    // Byte on the limit cycle keeps the frame alive
    f0 = ferr_seen;
    send_byte(8'hA5);
    idle(TO - 1);
    send_byte(8'h02);
    idle(TO - 1);
    send_byte(8'h03);
    model_frame(8'h02, 8'h03, 8'h00);
    wait_done();
    chk("limit_no_ferr", ferr_seen - f0, 0);

    // Backpressure with bytes arriving during the response
    tx_ready = 1'b0;
    send_frame(3, 8'h02, 8'h03, 8'h00);
    idle(10);
    send_byte(8'h11);
    send_byte(8'hA5);
    idle(38);
    chk("bp_vld", tx_data_vld, 1);
    chk("bp_status", tx_data, 8'h5A);
    tx_ready = 1'b1;
    wait_done();
    send_byte(8'h02);
    send_byte(8'h00);
    idle(5);
    chk("bp_dropped_busy", busy, 0);

    // Reset while VALUE is offered
    tx_ready = 1'b0;
    send_frame(3, 8'h02, 8'h00, 8'h00);
    @(posedge clk); #1;
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    chk("tx1_vld", tx_data_vld, 1);
    chk("tx1_value", tx_data, 8'h3C);
    rst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    idle(3);
    rst = 1'b1;
    tx_ready = 1'b1;
    idle(1);
    send_frame(3, 8'h02, 8'h00, 8'h00);
    check_first(8'h5A, 8'hFF);
    wait_done();

    chk("ferr_total", ferr_seen, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
